// File: rtl/multicycle_controller.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback, runs the memory
// req/ack handshakes, holds the instruction register and counts retired instructions.
module multicycle_controller #(
    parameter int unsigned n       = 32,
    parameter int unsigned maxWait = 15,
    parameter int unsigned cntW    = 32
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imemReq,
    input  logic            imemAck,
    input  logic [n-1:0]    imemData,
    output logic [n-1:0]    instruction,
    output logic            dmemReq,
    output logic            dmemWrite,
    input  logic            dmemAck,
    input  logic            zero,
    output logic            pcEnable,
    output logic            memToReg,
    output logic            pcSrc,
    output logic            aluSrc,
    output logic            regDst,
    output logic            jump,
    output logic            writeEnable,
    output logic [3:0]      aluControl,
    output logic            halted,
    output logic            error,
    output logic [cntW-1:0] retired
);

    localparam int unsigned WaitW = $clog2(maxWait + 1);

    localparam logic [4:0] OpR    = 5'b00000;
    localparam logic [4:0] OpAddi = 5'b00001;
    localparam logic [4:0] OpLw   = 5'b00010;
    localparam logic [4:0] OpSw   = 5'b00011;
    localparam logic [4:0] OpBeq  = 5'b00100;
    localparam logic [4:0] OpJ    = 5'b00101;
    localparam logic [4:0] OpHalt = 5'b11111;

    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;

    typedef enum logic [2:0] {Fetch, Decode, Exec, Mem, Wb, Halt} state_t;

    state_t           state;
    logic [WaitW-1:0] waitCnt;
    logic [4:0]       opcode;
    logic             isImm;
    logic             legal;
    logic             timeout;
    logic [3:0]       aluOp;

    assign opcode  = instruction[n-1 -: 5];
    assign isImm   = (opcode == OpAddi) || (opcode == OpLw) || (opcode == OpSw);
    assign legal   = isImm || (opcode == OpR) || (opcode == OpBeq) || (opcode == OpJ);
    assign timeout = (waitCnt == WaitW'(maxWait - 1));

    always_comb begin
        aluOp = 4'b0000;
        if (opcode == OpR) begin
            aluOp = instruction[3:0];
        end else if (isImm) begin
            aluOp = AluAdd;
        end else if (opcode == OpBeq) begin
            aluOp = AluSub;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= Fetch;
            instruction <= '0;
            retired     <= '0;
            error       <= 1'b0;
            waitCnt     <= '0;
        end else begin
            unique case (state)
                Fetch: begin
                    if (imemAck) begin
                        instruction <= imemData;
                        state       <= Decode;
                    end else if (timeout) begin
                        state <= Halt;
                        error <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                Decode: begin
                    waitCnt <= '0;
                    if (opcode == OpHalt) begin
                        state <= Halt;
                    end else if (legal) begin
                        state <= Exec;
                    end else begin
                        state <= Halt;
                        error <= 1'b1;
                    end
                end
                Exec: begin
                    waitCnt <= '0;
                    if ((opcode == OpBeq) || (opcode == OpJ)) begin
                        retired <= retired + 1'b1;
                        state   <= Fetch;
                    end else if ((opcode == OpLw) || (opcode == OpSw)) begin
                        state <= Mem;
                    end else begin
                        state <= Wb;
                    end
                end
                Mem: begin
                    if (dmemAck) begin
                        waitCnt <= '0;
                        if (opcode == OpSw) begin
                            retired <= retired + 1'b1;
                            state   <= Fetch;
                        end else begin
                            state <= Wb;
                        end
                    end else if (timeout) begin
                        state <= Halt;
                        error <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                Wb: begin
                    waitCnt <= '0;
                    retired <= retired + 1'b1;
                    state   <= Fetch;
                end
                default: state <= Halt;
            endcase
        end
    end

    // Outputs are gated by reset so they read 0 while reset is held, even in Fetch.
    always_comb begin
        imemReq     = 1'b0;
        dmemReq     = 1'b0;
        dmemWrite   = 1'b0;
        pcEnable    = 1'b0;
        memToReg    = 1'b0;
        pcSrc       = 1'b0;
        aluSrc      = 1'b0;
        regDst      = 1'b0;
        jump        = 1'b0;
        writeEnable = 1'b0;
        aluControl  = 4'b0000;
        halted      = 1'b0;
        if (reset) begin
            unique case (state)
                Fetch: imemReq = 1'b1;
                Exec: begin
                    aluSrc     = isImm;
                    aluControl = aluOp;
                    if (opcode == OpBeq) begin
                        pcSrc    = zero;
                        pcEnable = 1'b1;
                    end
                    if (opcode == OpJ) begin
                        jump     = 1'b1;
                        pcEnable = 1'b1;
                    end
                end
                Mem: begin
                    dmemReq    = 1'b1;
                    dmemWrite  = (opcode == OpSw);
                    aluSrc     = 1'b1;
                    aluControl = aluOp;
                    pcEnable   = dmemAck && (opcode == OpSw);
                end
                Wb: begin
                    writeEnable = 1'b1;
                    regDst      = (opcode == OpR);
                    memToReg    = (opcode == OpLw);
                    aluSrc      = isImm;
                    aluControl  = aluOp;
                    pcEnable    = 1'b1;
                end
                Halt: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed and random instructions, each checked cycle by
// cycle against an expected trace built from the instruction's phase lengths.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        imemReq, imemAck;
    logic [31:0] imemData, instruction;
    logic        dmemReq, dmemWrite, dmemAck, zero;
    logic        pcEnable, memToReg, pcSrc, aluSrc, regDst, jump, writeEnable;
    logic [3:0]  aluControl;
    logic        halted, error;
    logic [31:0] retired;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] expRetired = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset(reset),
        .imemReq(imemReq), .imemAck(imemAck), .imemData(imemData),
        .instruction(instruction),
        .dmemReq(dmemReq), .dmemWrite(dmemWrite), .dmemAck(dmemAck),
        .zero(zero),
        .pcEnable(pcEnable), .memToReg(memToReg), .pcSrc(pcSrc), .aluSrc(aluSrc),
        .regDst(regDst), .jump(jump), .writeEnable(writeEnable),
        .aluControl(aluControl), .halted(halted), .error(error), .retired(retired)
    );

    // {imemReq,dmemReq,dmemWrite,pcEnable,memToReg,pcSrc,aluSrc,regDst,jump,writeEnable,
    //  halted,error,aluControl}
    function automatic logic [15:0] observed();
        return {imemReq, dmemReq, dmemWrite, pcEnable, memToReg, pcSrc, aluSrc, regDst, jump,
                writeEnable, halted, error, aluControl};
    endfunction

    task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        reset      = 1'b1;
        expRetired = 0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        check16({tag, "_rst_outs"}, observed(), 16'h0);
        check32({tag, "_rst_retired"}, retired, 32'h0);
        check32({tag, "_rst_instr"}, instruction, 32'h0);
        release_reset();
    endtask

    // One instruction: imem ack after flat wait cycles, dmem ack after dlat wait cycles.
    // zmode 0/1 fixes the zero flag, 2 randomizes it. abortAt >= 0 resets in that cycle.
    task automatic run_instr(input logic [31:0] instr, input int flat, input int dlat,
                             input int zmode, input int abortAt, input string tag);
        logic [4:0] op;
        logic [3:0] ac;
        bit isMem, isWb, isImm, zv;
        bit ir, dr, dw, pe, m2r, ps, as, rd, jp, we;
        int e, mEnd, last;
        op    = instr[31:27];
        isImm = (op == 5'd1) || (op == 5'd2) || (op == 5'd3);
        isMem = (op == 5'd2) || (op == 5'd3);
        isWb  = (op == 5'd0) || (op == 5'd1) || (op == 5'd2);
        ac    = (op == 5'd0) ? instr[3:0] : isImm ? 4'b0010 : (op == 5'd4) ? 4'b0110 : 4'b0000;
        e     = flat + 2;
        mEnd  = e + 1 + dlat;
        last  = (isMem ? mEnd : e) + (isWb ? 1 : 0);
        for (int c = 0; c <= last; c++) begin
            imemAck  = (c == flat) ? 1'b1 : (c > flat) ? 1'($urandom) : 1'b0;
            imemData = (c == flat) ? instr : $urandom;
            if (isMem && c > e && c <= mEnd) dmemAck = (c == mEnd);
            else dmemAck = 1'($urandom);
            zv   = (zmode == 2) ? 1'($urandom) : (zmode == 1);
            zero = zv;
            {ir, dr, dw, pe, m2r, ps, as, rd, jp, we} = '0;
            @(negedge clk);
            if (c <= flat) begin
                ir = 1;
            end else if (c == e) begin
                as = isImm;
                if (op == 5'd4) begin ps = zv; pe = 1; end
                if (op == 5'd5) begin jp = 1; pe = 1; end
            end else if (isMem && c > e && c <= mEnd) begin
                dr = 1; dw = (op == 5'd3); as = 1;
                pe = (c == mEnd) && (op == 5'd3);
            end else if (isWb && c == last && c > e) begin
                we = 1; rd = (op == 5'd0); m2r = (op == 5'd2); as = isImm; pe = 1;
            end
            check16($sformatf("%s_c%0d", tag, c), observed(),
                    {ir, dr, dw, pe, m2r, ps, as, rd, jp, we, 2'b00,
                     (c == e || (c > e && (isMem || isWb))) ? ac : 4'b0000});
            if (c == flat + 1) check32({tag, "_instr"}, instruction, instr);
            if (c == abortAt) begin
                #2;
                do_reset({tag, "_abort"});
                return;
            end
            @(posedge clk);
            #1;
        end
        expRetired++;
        check32({tag, "_retired"}, retired, expRetired);
    endtask

    // Halting opcode: fetch, decode, then several cycles parked in HALT.
    task automatic run_halt(input logic [31:0] instr, input int flat, input bit errExp,
                            input string tag);
        for (int c = 0; c < flat + 5; c++) begin
            imemAck  = (c == flat) ? 1'b1 : (c > flat) ? 1'($urandom) : 1'b0;
            imemData = (c == flat) ? instr : $urandom;
            dmemAck  = 1'($urandom);
            zero     = 1'($urandom);
            @(negedge clk);
            check16($sformatf("%s_c%0d", tag, c), observed(),
                    (c <= flat) ? 16'h8000 : (c == flat + 1) ? 16'h0 : {10'b0, 1'b1, errExp, 4'b0});
            @(posedge clk);
            #1;
        end
        check32({tag, "_retired"}, retired, expRetired);
        do_reset(tag);
    endtask

    task automatic run_timeout(input string tag);
        for (int c = 0; c < 18; c++) begin
            imemAck  = (c >= 15) ? 1'($urandom) : 1'b0;
            imemData = $urandom;
            dmemAck  = 1'($urandom);
            zero     = 1'($urandom);
            @(negedge clk);
            check16($sformatf("%s_c%0d", tag, c), observed(),
                    (c < 15) ? 16'h8000 : 16'h0030);
            @(posedge clk);
            #1;
        end
        check32({tag, "_retired"}, retired, expRetired);
        do_reset(tag);
    endtask

    initial begin
        logic [31:0] r;
        logic [4:0]  op;
        reset    = 1'b0;
        imemAck  = 1'b0;
        imemData = '0;
        dmemAck  = 1'b0;
        zero     = 1'b0;
        #1;
        check16("reset_outs", observed(), 16'h0);
        check32("reset_retired", retired, 32'h0);
        check32("reset_instr", instruction, 32'h0);
        release_reset();

        run_instr(32'h0800_0005, 0, 0, 2, -1, "addi");
        run_instr({5'b00010, 27'h0012345}, 0, 3, 2, -1, "lw_d3");
        run_instr({5'b00011, 27'h0054321}, 0, 3, 2, -1, "sw_d3");
        run_instr({5'b00100, 27'h0000010}, 0, 0, 1, -1, "beq_z1");
        run_instr({5'b00100, 27'h0000010}, 0, 0, 0, -1, "beq_z0");
        run_instr({5'b00101, 27'h0000abc}, 0, 0, 2, -1, "j");
        run_instr({5'b00000, 27'h0000007}, 2, 0, 2, -1, "r");

        for (int i = 0; i < 40; i++) begin
            r  = $urandom;
            op = 5'($urandom_range(0, 5));
            run_instr({op, r[26:0]}, $urandom_range(0, 4), $urandom_range(0, 4), 2, -1,
                      $sformatf("rnd%0d", i));
        end

        run_halt({5'b01010, 27'h0000123}, 1, 1'b1, "illegal");
        run_instr(32'h0800_0001, 0, 0, 2, -1, "after_illegal");
        run_halt({5'b11111, 27'h0}, 0, 1'b0, "halt");
        run_timeout("imem_timeout");
        run_instr({5'b00010, 27'h0000042}, 1, 5, 2, 6, "lw_abort");
        run_instr(32'h0800_0005, 0, 0, 2, -1, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
